led_pattern_engine: RTL and testbench

- Parametrised successor to the 8-bit LED shifter: drives a WIDTH-bit LED bank with selectable patterns (rotate, bounce, fill/drain, one-shot shift-out).
- Step rate comes from an internal programmable prescaler. Pass count is programmable.
- Uses a start/stop handshake and reports busy, a per-step pulse and a one-cycle done pulse.
- Sits between the board-level LED pins and the control FSM that sequences display effects.

---
 rtl/led_pattern_engine_if.sv | 28 ++
 rtl/led_pattern_engine.sv | 170 +++++++++++++++++
 tb/tb_led_pattern_engine.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/led_pattern_engine_if.sv
// rtl/led_pattern_engine_if.sv - control/status bundle between effect sequencer and LED pattern engine
interface led_pattern_engine_if #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 24,
    parameter int CNT_WIDTH = 8
);
    logic                 start;
    logic                 stop;
    logic [1:0]           mode;
    logic                 dir;
    logic [DIV_WIDTH-1:0] div;
    logic [CNT_WIDTH-1:0] cycles;
    logic [WIDTH-1:0]     seed;
    logic [WIDTH-1:0]     led;
    logic                 busy;
    logic                 step;
    logic                 done;

    modport master (
        output start, stop, mode, dir, div, cycles, seed,
        input  led, busy, step, done
    );

    modport slave (
        input  start, stop, mode, dir, div, cycles, seed,
        output led, busy, step, done
    );
endinterface

// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - WIDTH-bit LED pattern engine with prescaler, pass counter and start/stop handshake
module led_pattern_engine #(
    parameter int WIDTH     = 8,
    parameter int DIV_WIDTH = 24,
    parameter int CNT_WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    led_pattern_engine_if.slave bus
);
    localparam int SW = $clog2(2 * WIDTH + 1);

    localparam logic [1:0] M_ROTATE    = 2'd0;
    localparam logic [1:0] M_BOUNCE    = 2'd1;
    localparam logic [1:0] M_FILL      = 2'd2;
    localparam logic [1:0] M_SHIFT_OUT = 2'd3;

    localparam logic [SW-1:0] LEN_ROT  = SW'(WIDTH);
    localparam logic [SW-1:0] HALF_BNC = SW'(WIDTH - 1);
    localparam logic [SW-1:0] LEN_BNC  = SW'(2 * (WIDTH - 1));
    localparam logic [SW-1:0] LEN_FILL = SW'(2 * WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    state_t               state_next;

    logic [1:0]           mode_l;
    logic                 dir_r;
    logic [DIV_WIDTH-1:0] div_l;
    logic [CNT_WIDTH-1:0] cycles_l;
    logic [DIV_WIDTH-1:0] presc;
    logic [SW-1:0]        step_cnt;
    logic [CNT_WIDTH-1:0] pass_cnt;
    logic [WIDTH-1:0]     led_r;
    logic                 busy_r;
    logic                 step_r;
    logic                 done_r;

    logic                 tick;
    logic [SW-1:0]        step_inc;
    logic [SW-1:0]        pass_len;
    logic                 pass_end;
    logic [CNT_WIDTH-1:0] pass_inc;
    logic                 fill_bit;
    logic [WIDTH-1:0]     led_next;
    logic                 flip;
    logic                 finish;

    assign bus.led  = led_r;
    assign bus.busy = busy_r;
    assign bus.step = step_r;
    assign bus.done = done_r;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, next LED pattern and pass bookkeeping for the current tick
    always_comb begin
        state_next = state;
        tick       = (presc == div_l);
        step_inc   = step_cnt + SW'(1);
        pass_inc   = pass_cnt + CNT_WIDTH'(1);
        fill_bit   = (step_cnt < LEN_ROT);
        led_next   = led_r;
        flip       = 1'b0;

        case (mode_l)
            M_ROTATE: pass_len = LEN_ROT;
            M_BOUNCE: pass_len = LEN_BNC;
            default:  pass_len = LEN_FILL;
        endcase
        // Shift-out has no pass structure; it ends on the all-zero result instead
        pass_end = (mode_l != M_SHIFT_OUT) && (step_inc == pass_len);

        case (mode_l)
            M_ROTATE, M_BOUNCE: led_next = dir_r ? {led_r[WIDTH-2:0], led_r[WIDTH-1]}
                                                 : {led_r[0], led_r[WIDTH-1:1]};
            M_FILL:             led_next = dir_r ? {led_r[WIDTH-2:0], fill_bit}
                                                 : {fill_bit, led_r[WIDTH-1:1]};
            default:            led_next = dir_r ? {led_r[WIDTH-2:0], 1'b0}
                                                 : {1'b0, led_r[WIDTH-1:1]};
        endcase

        // Bounce reverses at both ends of the bank, which also restores the original direction at pass end
        flip = (mode_l == M_BOUNCE) && ((step_inc == HALF_BNC) || (step_inc == LEN_BNC));

        if (mode_l == M_SHIFT_OUT) begin
            finish = (led_next == '0);
        end else begin
            finish = pass_end && (cycles_l != '0) && (pass_inc == cycles_l);
        end

        case (state)
            IDLE: if (bus.start) state_next = RUN;
            RUN: begin
                if (bus.stop) begin
                    state_next = IDLE;
                end else if (tick && finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: load on start, advance pattern and counters on each tick, stop has priority over tick
    always_ff @(posedge clk) begin
        if (reset) begin
            led_r    <= '0;
            busy_r   <= 1'b0;
            step_r   <= 1'b0;
            done_r   <= 1'b0;
            presc    <= '0;
            step_cnt <= '0;
            pass_cnt <= '0;
            dir_r    <= 1'b0;
            mode_l   <= '0;
            div_l    <= '0;
            cycles_l <= '0;
        end else begin
            step_r <= 1'b0;
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        led_r    <= bus.seed;
                        mode_l   <= bus.mode;
                        dir_r    <= bus.dir;
                        div_l    <= bus.div;
                        cycles_l <= bus.cycles;
                        presc    <= '0;
                        step_cnt <= '0;
                        pass_cnt <= '0;
                        busy_r   <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        busy_r <= 1'b0;
                    end else if (tick) begin
                        presc  <= '0;
                        led_r  <= led_next;
                        step_r <= 1'b1;
                        if (flip) dir_r <= ~dir_r;
                        if (pass_end) begin
                            step_cnt <= '0;
                            pass_cnt <= pass_inc;
                        end else begin
                            step_cnt <= step_inc;
                        end
                        if (finish) begin
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                        end
                    end else begin
                        presc <= presc + DIV_WIDTH'(1);
                    end
                end
                default: busy_r <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - scoreboard bench for led_pattern_engine
module tb_led_pattern_engine;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    led_pattern_engine_if #(.WIDTH(8), .DIV_WIDTH(24), .CNT_WIDTH(8)) bus ();

    led_pattern_engine #(.WIDTH(8), .DIV_WIDTH(24), .CNT_WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [7:0] led;
        logic       done;
        logic [7:0] gap;
    } exp_t;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   done_count = 0;

    task automatic push(input logic [7:0] l, input logic d, input int g);
        exp_t e;
        e.led  = l;
        e.done = d;
        e.gap  = g[7:0];
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic do_start(input logic [1:0] m, input logic d, input logic [23:0] dv,
                            input logic [7:0] cy, input logic [7:0] sd);
        bus.mode   = m;
        bus.dir    = d;
        bus.div    = dv;
        bus.cycles = cy;
        bus.seed   = sd;
        bus.start  = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout no done within %0d cycles", name, budget);
            exp_q.delete();
        end
        check({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic finish_case(input string name, input logic [7:0] final_led);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check({name, "_led_hold"}, 32'(bus.led), 32'(final_led));
        check({name, "_busy_idle"}, 32'(bus.busy), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: pop one expectation per step pulse and check value, done flag and spacing
    initial begin : monitor
        int   cnt;
        logic prev_busy;
        exp_t e;
        cnt       = 0;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            cnt++;
            if (bus.done && !bus.step) begin
                checks++;
                errors++;
                $display("FAIL done_without_step led=%0h", bus.led);
            end
            if (bus.step) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_step led=%0h", bus.led);
                end else begin
                    e = exp_q.pop_front();
                    check("step_led", 32'(bus.led), 32'(e.led));
                    check("step_done", 32'(bus.done), 32'(e.done));
                    check("step_gap", 32'(cnt), 32'(e.gap));
                end
                cnt = 0;
            end
            if (bus.busy && !prev_busy) cnt = 0;
            if (bus.done) done_count++;
            prev_busy = bus.busy;
        end
    end

    logic [7:0] fill_vec [16];

    initial begin
        fill_vec = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                     8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.stop   = 1'b0;
        bus.mode   = 2'd0;
        bus.dir    = 1'b0;
        bus.div    = '0;
        bus.cycles = '0;
        bus.seed   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_led", 32'(bus.led), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_step", 32'(bus.step), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Rotate left one pass
        for (int i = 1; i < 8; i++) push(8'(1 << i), 1'b0, 1);
        push(8'h01, 1'b1, 1);
        do_start(2'd0, 1'b1, 24'd0, 8'd1, 8'h01);
        check("rot_load_led", 32'(bus.led), 32'h01);
        check("rot_load_busy", 32'(bus.busy), 32'd1);
        wait_done("rot", 200);
        finish_case("rot", 8'h01);

        // Shift-out right, then zero seed started in the cycle after done
        push(8'h48, 1'b0, 3); push(8'h24, 1'b0, 3); push(8'h12, 1'b0, 3); push(8'h09, 1'b0, 3);
        push(8'h04, 1'b0, 3); push(8'h02, 1'b0, 3); push(8'h01, 1'b0, 3); push(8'h00, 1'b1, 3);
        do_start(2'd3, 1'b0, 24'd2, 8'd0, 8'h90);
        wait_done("shift", 200);
        push(8'h00, 1'b1, 3);
        do_start(2'd3, 1'b0, 24'd2, 8'd5, 8'h00);
        check("shift0_busy", 32'(bus.busy), 32'd1);
        wait_done("shift0", 50);
        finish_case("shift0", 8'h00);

        // Bounce, two passes
        for (int p = 0; p < 2; p++) begin
            for (int i = 1; i < 8; i++) push(8'(1 << i), 1'b0, 1);
            for (int i = 6; i >= 0; i--) push(8'(1 << i), (p == 1 && i == 0), 1);
        end
        do_start(2'd1, 1'b1, 24'd0, 8'd2, 8'h01);
        wait_done("bounce", 200);
        finish_case("bounce", 8'h01);

        // Fill then drain
        for (int i = 0; i < 16; i++) push(fill_vec[i], (i == 15), 1);
        do_start(2'd2, 1'b1, 24'd0, 8'd1, 8'h00);
        wait_done("fill", 200);
        finish_case("fill", 8'h00);

        // Free-running rotate, ignored mid-run start, stop coincident with tick 14
        for (int i = 1; i <= 13; i++) push(8'(1 << (i % 8)), 1'b0, 5);
        do_start(2'd0, 1'b1, 24'd4, 8'd0, 8'h01);
        repeat (20) @(posedge clk);
        #1;
        bus.seed  = 8'hAA;
        bus.mode  = 2'd3;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (48) @(posedge clk);
        #1 bus.stop = 1'b1;
        @(posedge clk);
        #1 bus.stop = 1'b0;
        check("stop_led", 32'(bus.led), 32'h20);
        check("stop_step", 32'(bus.step), 32'd0);
        check("stop_done", 32'(bus.done), 32'd0);
        check("stop_busy", 32'(bus.busy), 32'd0);
        finish_case("stop", 8'h20);

        // Restart after stop reloads seed, then stop before any tick
        do_start(2'd0, 1'b1, 24'd4, 8'd0, 8'h5A);
        check("restart_led", 32'(bus.led), 32'h5A);
        check("restart_busy", 32'(bus.busy), 32'd1);
        bus.stop = 1'b1;
        @(posedge clk);
        #1 bus.stop = 1'b0;
        finish_case("restart", 8'h5A);

        // Reset mid-run, then reset and start together, then a normal run
        push(8'h02, 1'b0, 4);
        push(8'h04, 1'b0, 4);
        do_start(2'd1, 1'b1, 24'd3, 8'd0, 8'h01);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_led", 32'(bus.led), 32'd0);
        check("midreset_busy", 32'(bus.busy), 32'd0);
        check("midreset_step", 32'(bus.step), 32'd0);
        check("midreset_done", 32'(bus.done), 32'd0);
        check("midreset_queue", 32'(exp_q.size()), 32'd0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        bus.start = 1'b0;
        check("reset_start_busy", 32'(bus.busy), 32'd0);
        check("reset_start_led", 32'(bus.led), 32'd0);
        for (int i = 1; i < 8; i++) push(8'(1 << i), 1'b0, 1);
        push(8'h01, 1'b1, 1);
        do_start(2'd0, 1'b1, 24'd0, 8'd1, 8'h01);
        wait_done("rot2", 200);
        finish_case("rot2", 8'h01);

        check("done_total", 32'(done_count), 32'd6);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
